add_seq_ctrl: RTL and testbench
===============================

# add_seq_ctrl

Multi-precision add/subtract sequencer that reuses one `adder_8bit` ripple-carry slice across `NBYTES` cycles to produce a `8*NBYTES`-bit result. It captures operands on a start pulse and walks the bytes LSB-first, chaining the registered carry into the next byte. It then presents the result with a one-cycle `done` pulse. It sits between a host/register interface and the shared 8-bit adder datapath, trading latency for area.

## Interface
- `NBYTES`, default 4: operand width in bytes; legal range 2..16.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request; sampled only in IDLE or DONE.
- `sub`  in  1: 0 = A+B+cin, 1 = A−B (B inverted, `cin` ignored, carry-in forced to 1); captured with `start`.
- `cin`  in  1: carry-in for add mode; captured with `start`.
- `a`  in  8*NBYTES: operand A; captured with `start`.
- `b`  in  8*NBYTES: operand B; captured with `start`.
- `busy`  out  1: high in RUN.
- `done`  out  1: one-cycle pulse, high in DONE.
- `sum`  out  8*NBYTES: result register.
- `cout`  out  1: final carry-out. In sub mode, 1 = no borrow.
- `ovf`  out  1: signed two's-complement overflow of the full-width result.

## Operation
- FSM states:
  - IDLE: `start` → RUN.
  - RUN: byte index `idx` == NBYTES−1 → DONE, else stay.
  - DONE: `start` → RUN, else → IDLE.
- On accepted `start`:
  - A_r ← a.
  - B_r ← sub ? ~b : b.
  - carry_r ← sub ? 1 : cin.
  - idx ← 0.
  - `sum` cleared to 0.
  - sub_r latched.
- Each RUN cycle:
  - Adder inputs are A_r[8*idx +: 8], B_r[8*idx +: 8] and carry_r.
  - sum[8*idx +: 8] ← adder sum.
  - carry_r ← adder cout.
  - idx ← idx+1.
- Final RUN cycle (idx == NBYTES−1):
  - cout ← adder cout.
  - ovf ← (A_r MSB == B_r MSB) && (adder sum bit 7 != A_r MSB).
- `sum`, `cout` and `ovf` hold their values after DONE until the next accepted `start`.
- `start` during RUN is ignored; no queuing.
- `a`, `b`, `sub` and `cin` may change freely after the capture edge.
- `rst` at any time, including mid-RUN, takes effect on the next edge. The operation is abandoned and no `done` is produced.
- Arithmetic is modulo 2^(8*NBYTES).

## Timing
- Reset values: state IDLE, idx 0, `busy` 0, `done` 0, `sum` 0, `cout` 0, `ovf` 0, carry_r 0.
- Latency: with `start` high in cycle 0, the cycles run as follows.
  - Cycles 1..NBYTES are RUN with `busy` = 1.
  - Cycle NBYTES+1 is DONE with `done` = 1 and all results valid.
- Back-to-back: `start` in the DONE cycle begins the next op in the following cycle. Throughput is one op per NBYTES+1 cycles.
- `busy` and `done` are never high together.
- Outputs are registered; there is no combinational path from inputs to outputs.
- The adder slice is purely combinational, so one byte per cycle is the critical path: 8-stage ripple plus mux.

## Structure
- Shared package `add_seq_pkg` holds:
  - the state encoding constants (IDLE, RUN, DONE), 2-bit;
  - the `IDX_W` = clog2(NBYTES) helper.
- One sub-module instance: `adder_8bit`, unmodified. It is the only arithmetic in the block; byte selection muxes and registers live in the top.

## Test plan
- Reset/idle: assert `rst` 2 cycles, no `start` → all outputs 0 and state IDLE for 10 cycles.
- Carry chain (NBYTES=4): a=0x00FF_FFFF, b=0x0000_0001, cin=0, sub=0 → `done` in cycle 5, sum=0x0100_0000, cout=0, ovf=0.
- Full wrap and signed overflow:
  - a=0xFFFF_FFFF, b=0x0000_0001, cin=0 → sum=0, cout=1, ovf=0.
  - a=0x7FFF_FFFF, b=1, cin=0 → sum=0x8000_0000, cout=0, ovf=1.
- Subtract: sub=1, a=0x0000_0005, b=0x0000_0007 → sum=0xFFFF_FFFE, cout=0 (borrow), ovf=0. Also a=0x8000_0000, b=1 → sum=0x7FFF_FFFF, ovf=1.
- Back-to-back and ignored start:
  - Two ops, the second's `start` in the first's DONE cycle → `done` in cycles 5 and 10.
  - A `start` pulse in cycle 2 is ignored and does not alter the result.
- Reset mid-operation: `rst` in cycle 3 of a RUN → no `done`, outputs 0, next op correct.

Source files
------------

// File: rtl/add_seq_pkg.sv
// Shared definitions for the byte-serial add/subtract sequencer.
package add_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Byte-index width; never below 1 so the index register always exists.
    function automatic int idx_w(input int nbytes);
        return (nbytes <= 2) ? 1 : $clog2(nbytes);
    endfunction

endpackage

// File: rtl/adder_8bit.sv
// 8-bit ripple-carry adder slice, purely combinational.
// Latency: 0 cycles. Backpressure: none.
// Critical path is the 8-stage carry ripple.
module adder_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [8:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < 8; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[8];
    end

endmodule

// File: rtl/add_seq_ctrl.sv
// Multi-precision add/sub: one shared 8-bit slice walked LSB-first over NBYTES cycles.
// Latency: NBYTES+1 cycles from start to the one-cycle done pulse.
// Backpressure: none; start is accepted only in IDLE or DONE, ignored while busy.
module add_seq_ctrl
    import add_seq_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  sub,
    input  logic                  cin,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   sum,
    output logic                  cout,
    output logic                  ovf
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = idx_w(NBYTES);
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    state_t          state;
    state_t          state_nxt;
    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;
    logic            carry_r;
    logic [IW-1:0]   idx;
    logic            accept;
    logic            last;
    logic [IW+2:0]   bit_base;
    logic [7:0]      a_byte;
    logic [7:0]      b_byte;
    logic [7:0]      add_sum;
    logic            add_cout;

    assign accept   = start && ((state == IDLE) || (state == DONE));
    assign last     = (state == RUN) && (idx == LAST);
    assign bit_base = {idx, 3'b000};
    assign a_byte   = a_r[bit_base +: 8];
    assign b_byte   = b_r[bit_base +: 8];

    adder_8bit u_adder (
        .a    (a_byte),
        .b    (b_byte),
        .cin  (carry_r),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? RUN : IDLE;
            RUN:     state_nxt = (idx == LAST) ? DONE : RUN;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // Subtraction is A + ~B + 1, so B is inverted once at capture and the slice only adds.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r     <= '0;
            b_r     <= '0;
            carry_r <= 1'b0;
            idx     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else if (accept) begin
            a_r     <= a;
            b_r     <= sub ? ~b : b;
            carry_r <= sub ? 1'b1 : cin;
            idx     <= '0;
            sum     <= '0;
        end else if (state == RUN) begin
            sum[bit_base +: 8] <= add_sum;
            carry_r            <= add_cout;
            idx                <= last ? '0 : idx + 1'b1;
            if (last) begin
                cout <= add_cout;
                ovf  <= (a_r[W-1] == b_r[W-1]) && (add_sum[7] != a_r[W-1]);
            end
        end
    end

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Scoreboard bench: stimulus pushes arithmetic-model results, a negedge monitor checks each done.
module tb_add_seq_ctrl;

    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           cyc;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           sub;
    logic           cin;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [W-1:0]   sum;
    logic           cout;
    logic           ovf;

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    exp_t sb_q[$];
    exp_t last_e;

    add_seq_ctrl #(.NBYTES(NBYTES)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .cin   (cin),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: full-precision integer arithmetic, no byte walking.
    function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                   input logic ts, input logic tc);
        exp_t            e;
        longint          sa, sb, sr, lim;
        longint unsigned ur;
        sa  = longint'($signed(ta));
        sb  = longint'($signed(tb_));
        lim = longint'(1) << (W - 1);
        if (ts) begin
            ur     = 64'(ta) - 64'(tb_);
            sr     = sa - sb;
            e.cout = (ta >= tb_);
        end else begin
            ur     = 64'(ta) + 64'(tb_) + 64'(tc);
            sr     = sa + sb + longint'(tc);
            e.cout = ur[W];
        end
        e.sum = ur[W-1:0];
        e.ovf = (sr >= lim) || (sr < -lim);
        e.cyc = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            check("busy_with_done", 64'(busy), 64'd0);
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
            end else begin
                e = sb_q.pop_front();
                check("done_cycle", 64'(cyc), 64'(e.cyc));
                check("sum", 64'(sum), 64'(e.sum));
                check("cout", 64'(cout), 64'(e.cout));
                check("ovf", 64'(ovf), 64'(e.ovf));
            end
        end
    end

    // Issued on a negedge; returns on the negedge of the last RUN cycle.
    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic ts, input logic tc, input bit ign);
        exp_t e;
        e     = model(ta, tb_, ts, tc);
        e.cyc = cyc + 1 + NBYTES;
        sb_q.push_back(e);
        last_e = e;
        a = ta; b = tb_; sub = ts; cin = tc; start = 1'b1;
        for (int i = 0; i < NBYTES; i++) begin
            @(negedge clk);
            if (i == 0) check("busy_run", 64'(busy), 64'd1);
            start = ign && (i == 1);
            a     = $urandom;
            b     = $urandom;
            sub   = 1'($urandom);
            cin   = 1'($urandom);
        end
    endtask

    task automatic directed(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                            input logic ts, input logic tc, input bit ign);
        issue(ta, tb_, ts, tc, ign);
        @(negedge clk);
        @(negedge clk);
        check("hold_sum", 64'(sum), 64'(last_e.sum));
        check("hold_cout", 64'(cout), 64'(last_e.cout));
        check("hold_ovf", 64'(ovf), 64'(last_e.ovf));
        check("idle_done", 64'(done), 64'd0);
        @(negedge clk);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return {1'b0, {(W-1){1'b1}}};
            3:       return {1'b1, {(W-1){1'b0}}};
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int wait_cnt;
        rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("reset_idle", {29'd0, busy, done, cout, ovf, sum}, 64'd0);
        end

        directed(32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        directed(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        directed(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        directed(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 1'b0);
        directed(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 1'b0);
        directed(32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b1, 1'b1);

        // Back-to-back: second start lands in the first op's DONE cycle.
        issue(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        issue(32'hDEAD_BEEF, 32'h0000_BEEF, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);

        // Reset in cycle 3 of a RUN abandons the op.
        a = 32'h0102_0304; b = 32'h1111_1111; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < NBYTES + 3; i++) begin
            @(negedge clk);
            check("post_reset_idle", {29'd0, busy, done, cout, ovf, sum}, 64'd0);
        end
        directed(32'h0000_0100, 32'h0000_0001, 1'b1, 1'b0, 1'b0);

        for (int n = 0; n < 150; n++) begin
            issue(pick(), pick(), 1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0);
            @(negedge clk);
            if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        start = 1'b0;

        wait_cnt = 0;
        while (sb_q.size() != 0 && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
